mips_main_control: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 62 ++++++
 rtl/mips_main_control_if.sv | 40 ++++
 rtl/mips_ctrl_decode.sv | 33 +++
 rtl/mips_main_control.sv | 50 +++++
 tb/tb_mips_main_control.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings and control-word type for the MIPS main control decoder
//
// Purpose : opcode and ALUop constants, the packed control word carried from
//           the decoder to the output register, and the strobe-derivation helper.
// Contents: OP_* opcode constants, ALUOP_* constants, ctrl_word_t,
//           ctrl_apply_strobes().
package mips_ctrl_pkg;

  // Opcode field ins[31:26] encodings of the supported instruction classes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUop handed to the ALU-function decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Control word in output-port order; an all-zero word is the NOP-safe state
  typedef struct packed {
    logic       rtype;
    logic       lw;
    logic       sw;
    logic       addi;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       RegDst;
    logic       ALUSrc;
    logic       RegWrite;
    logic       Mem2Reg;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUop;
  } ctrl_word_t;

  // Takes a word with only the class flags set and fills in the strobes and
  // ALUop. jump and illegal contribute to no strobe, so both come out as NOPs
  // from the datapath's point of view.
  function automatic ctrl_word_t ctrl_apply_strobes(input ctrl_word_t cls);
    ctrl_word_t w;
    w          = cls;
    w.RegDst   = cls.rtype;
    w.ALUSrc   = cls.lw | cls.sw | cls.addi;
    w.RegWrite = cls.rtype | cls.lw | cls.addi;
    w.Mem2Reg  = cls.lw;
    w.MemRead  = cls.lw;
    w.MemWrite = cls.sw;
    if (cls.rtype) begin
      w.ALUop = ALUOP_FUNCT;
    end else if (cls.branch) begin
      w.ALUop = ALUOP_SUB;
    end else begin
      w.ALUop = ALUOP_ADD;
    end
    return w;
  endfunction

endpackage

// File: rtl/mips_main_control_if.sv
// rtl/mips_main_control_if.sv - opcode/enable input and control-strobe bundle of the main control decoder
//
// Purpose : groups the update enable, the opcode field and all registered
//           control outputs into one bundle.
// Modports: master - drives en/opCode, observes the control outputs (fetch side)
//           slave  - receives en/opCode, drives the control outputs (decoder)
interface mips_main_control_if;
  import mips_ctrl_pkg::*;

  logic       en;
  logic [5:0] opCode;

  logic       rtype;
  logic       lw;
  logic       sw;
  logic       addi;
  logic       branch;
  logic       jump;
  logic       illegal;
  logic       RegDst;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Mem2Reg;
  logic       MemRead;
  logic       MemWrite;
  logic [1:0] ALUop;

  modport master (
    output en, opCode,
    input  rtype, lw, sw, addi, branch, jump, illegal,
    input  RegDst, ALUSrc, RegWrite, Mem2Reg, MemRead, MemWrite, ALUop
  );

  modport slave (
    input  en, opCode,
    output rtype, lw, sw, addi, branch, jump, illegal,
    output RegDst, ALUSrc, RegWrite, Mem2Reg, MemRead, MemWrite, ALUop
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational opcode-to-control-word decoder
//
// Purpose : classifies the 6-bit opcode into exactly one class flag (or
//           illegal) and derives the datapath strobes and ALUop.
// Ports   : op_code_i [5:0] - instruction bits [31:26]
//           ctrl_o          - full control word (ctrl_word_t)
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_code_i,
  output ctrl_word_t ctrl_o
);

  ctrl_word_t cls_flags;

  // A single case with a default guarantees exactly one flag is set for
  // every opcode, which keeps the class flags one-hot by construction.
  always_comb begin
    cls_flags = '0;
    case (op_code_i)
      OP_RTYPE: cls_flags.rtype   = 1'b1;
      OP_LW:    cls_flags.lw      = 1'b1;
      OP_SW:    cls_flags.sw      = 1'b1;
      OP_ADDI:  cls_flags.addi    = 1'b1;
      OP_BEQ:   cls_flags.branch  = 1'b1;
      OP_J:     cls_flags.jump    = 1'b1;
      default:  cls_flags.illegal = 1'b1;
    endcase
  end

  assign ctrl_o = ctrl_apply_strobes(cls_flags);

endmodule

// File: rtl/mips_main_control.sv
// rtl/mips_main_control.sv - registered main control decoder for the single-cycle MIPS subset
//
// Purpose : decodes opCode through mips_ctrl_decode and registers the control
//           word with enable and asynchronous clear.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset, clears every output
//           bus   - slave side of mips_main_control_if (en, opCode in;
//                   class flags, strobes and ALUop out)
module mips_main_control
  import mips_ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  mips_main_control_if.slave         bus
);

  ctrl_word_t ctrl_d;
  ctrl_word_t ctrl_q;

  mips_ctrl_decode u_decode (
    .op_code_i (bus.opCode),
    .ctrl_o    (ctrl_d)
  );

  // The output register is the only state. Clearing to zero (illegal=0
  // included) gives a NOP-safe word until the first enabled update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (bus.en) begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.rtype    = ctrl_q.rtype;
  assign bus.lw       = ctrl_q.lw;
  assign bus.sw       = ctrl_q.sw;
  assign bus.addi     = ctrl_q.addi;
  assign bus.branch   = ctrl_q.branch;
  assign bus.jump     = ctrl_q.jump;
  assign bus.illegal  = ctrl_q.illegal;
  assign bus.RegDst   = ctrl_q.RegDst;
  assign bus.ALUSrc   = ctrl_q.ALUSrc;
  assign bus.RegWrite = ctrl_q.RegWrite;
  assign bus.Mem2Reg  = ctrl_q.Mem2Reg;
  assign bus.MemRead  = ctrl_q.MemRead;
  assign bus.MemWrite = ctrl_q.MemWrite;
  assign bus.ALUop    = ctrl_q.ALUop;

endmodule

// File: tb/tb_mips_main_control.sv
// tb/tb_mips_main_control.sv - directed self-checking bench for mips_main_control
module tb_mips_main_control;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  mips_main_control_if bus_if ();

  mips_main_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: rtype lw sw addi branch jump illegal | RegDst ALUSrc RegWrite
  //            Mem2Reg MemRead MemWrite | ALUop[1:0]
  localparam logic [14:0] E_ZERO  = 15'b0000000_000000_00;
  localparam logic [14:0] E_RTYPE = 15'b1000000_101000_10;
  localparam logic [14:0] E_LW    = 15'b0100000_011110_00;
  localparam logic [14:0] E_SW    = 15'b0010000_010001_00;
  localparam logic [14:0] E_ADDI  = 15'b0001000_011000_00;
  localparam logic [14:0] E_BEQ   = 15'b0000100_000000_01;
  localparam logic [14:0] E_J     = 15'b0000010_000000_00;
  localparam logic [14:0] E_ILL   = 15'b0000001_000000_00;

  function automatic logic [14:0] obs_word();
    return {bus_if.rtype, bus_if.lw, bus_if.sw, bus_if.addi, bus_if.branch,
            bus_if.jump, bus_if.illegal, bus_if.RegDst, bus_if.ALUSrc,
            bus_if.RegWrite, bus_if.Mem2Reg, bus_if.MemRead, bus_if.MemWrite,
            bus_if.ALUop};
  endfunction

  function automatic logic [14:0] model_word(input logic [5:0] op);
    case (op)
      6'b000000: return E_RTYPE;
      6'b100011: return E_LW;
      6'b101011: return E_SW;
      6'b001000: return E_ADDI;
      6'b000100: return E_BEQ;
      6'b000010: return E_J;
      default:   return E_ILL;
    endcase
  endfunction

  task automatic check(input string tag, input logic [14:0] expected);
    logic [14:0] observed;
    observed = obs_word();
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic [5:0] op, input logic en);
    @(negedge clk);
    bus_if.opCode = op;
    bus_if.en     = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [14:0] w;
    n_assert = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus_if.en     = 1'b1;
    bus_if.opCode = 6'b000000;

    // Reset: outputs stay clear with en=1 and the clock running
    repeat (3) @(posedge clk);
    #1;
    check("reset_clear", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_rtype", E_RTYPE);

    // lw / sw
    step(6'b100011, 1'b1); check("lw", E_LW);
    step(6'b101011, 1'b1); check("sw", E_SW);

    // beq / j
    step(6'b000100, 1'b1); check("beq", E_BEQ);
    step(6'b000010, 1'b1); check("j", E_J);

    // addi / illegal
    step(6'b001000, 1'b1); check("addi", E_ADDI);
    step(6'b111111, 1'b1); check("illegal_3f", E_ILL);

    // Hold: lw loaded, en low for three edges with sw on the bus
    step(6'b100011, 1'b1); check("hold_load_lw", E_LW);
    step(6'b101011, 1'b0); check("hold_edge1", E_LW);
    step(6'b101011, 1'b0); check("hold_edge2", E_LW);
    step(6'b101011, 1'b0); check("hold_edge3", E_LW);
    step(6'b101011, 1'b1); check("hold_release_sw", E_SW);

    // Async reset between edges while rtype is loaded
    step(6'b000000, 1'b1); check("async_pre_rtype", E_RTYPE);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_midcycle", E_ZERO);
    @(posedge clk);
    #1;
    check("async_held_over_edge", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.opCode = 6'b100011;
    @(posedge clk);
    #1;
    check("async_release_lw", E_LW);

    // Exhaustive sweep: full word against the table and one-hot class/illegal
    for (int i = 0; i < 64; i++) begin
      step(6'(i), 1'b1);
      check($sformatf("sweep_op_%02h", i), model_word(6'(i)));
      w = obs_word();
      n_assert++;
      assert ($countones(w[14:8]) == 1) else begin
        n_fail++;
        $error("FAIL onehot_op_%02h observed_flags=%b required=exactly one set", i, w[14:8]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
